// File: rtl/dilithium_vy_sequencer.sv
// Dilithium verify sequencer: resets and starts the core, streams the
// verify vector fields from memory through a 2-entry FIFO, collects result.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start_i, msg_len_i             host start request, message length (bytes)
//   busy_o, done_o, accept_o       status; done_o is a 1-cycle pulse
//   cyc_total_o                    cycle count of the last operation
//   mem_rd_o/field/word, mem_data_i  vector memory read (1-cycle latency)
//   core_rst_o, core_start_o       core control
//   core_valid_o/ready_i/data_o    word stream into the core
//   core_valid_i/ready_o/data_i    result from the core
module dilithium_vy_sequencer #(
   parameter int W          = 64,
   parameter int HIGH_PERF  = 1,
   parameter int SEED_WORDS = 4,
   parameter int Z_WORDS    = 4,
   parameter int T1_WORDS   = 4,
   parameter int H_WORDS    = 4,
   parameter int RST_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [31:0]  msg_len_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         accept_o,
   output logic [31:0]  cyc_total_o,
   output logic         mem_rd_o,
   output logic [2:0]   mem_field_o,
   output logic [9:0]   mem_word_o,
   input  logic [W-1:0] mem_data_i,
   output logic         core_rst_o,
   output logic         core_start_o,
   output logic         core_valid_o,
   input  logic         core_ready_i,
   output logic [W-1:0] core_data_o,
   input  logic         core_valid_i,
   output logic         core_ready_o,
   input  logic [W-1:0] core_data_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRST,
      S_CSTART,
      S_STREAM,
      S_RESULT,
      S_DONE
   } state_t;

   localparam logic [2:0] F_MLEN  = 3'd4;
   localparam logic [2:0] F_MSG   = 3'd5;
   localparam logic [3:0] RC_LAST = 4'(RST_CYCLES - 1);

   state_t        state_q;
   logic [3:0]    rc_q;
   logic [31:0]   msg_len_q;
   logic [34:0]   msg_rem_q;
   logic [2:0]    pos_q;
   logic [9:0]    word_q;
   logic          iss_done_q;
   logic          infl_q;
   logic          infl_mlen_q;
   logic [W-1:0]  fifo0_q;
   logic [W-1:0]  fifo1_q;
   logic          rp_q;
   logic          wp_q;
   logic [1:0]    cnt_q;
   logic [1:0]    cnt_d;
   logic          busy_q;
   logic          done_q;
   logic          accept_q;
   logic [31:0]   cyc_q;
   logic [31:0]   tot_q;
   logic          crst_q;
   logic          cstart_q;
   logic          cready_q;

   logic [2:0]    fld;
   logic          is_msg;
   logic          is_mlen;
   logic          last;
   logic          pop;
   logic          push;
   logic          issue;
   logic          fin;
   logic [2:0]    occ;
   logic [W-1:0]  head;
   logic [W-1:0]  pdata;
   logic [31:0]   cyc_inc;

   // Field code sent at each position of the stream.
   function automatic logic [2:0] fld_at(input logic [2:0] p);
      logic [2:0] f;
      f = p;
      if (HIGH_PERF == 0) begin
         case (p)
            3'd0:    f = 3'd0;
            3'd1:    f = 3'd3;
            3'd2:    f = 3'd1;
            3'd3:    f = 3'd2;
            3'd4:    f = 3'd6;
            3'd5:    f = 3'd4;
            default: f = 3'd5;
         endcase
      end
      return f;
   endfunction

   // Word count of the fixed-size fields (MSG is handled separately).
   function automatic logic [9:0] nwords(input logic [2:0] f);
      logic [9:0] n;
      case (f)
         3'd0, 3'd1: n = 10'(SEED_WORDS);
         3'd2:       n = 10'(Z_WORDS);
         3'd3:       n = 10'(T1_WORDS);
         3'd6:       n = 10'(H_WORDS);
         default:    n = 10'd1;
      endcase
      return n;
   endfunction

   assign fld     = fld_at(pos_q);
   assign is_msg  = (fld == F_MSG);
   assign is_mlen = (fld == F_MLEN);

   // MSG length is tracked in remaining bits, so no divider is needed;
   // msg_len=0 still yields one word because 0 <= W.
   assign last = is_msg ? (msg_rem_q <= 35'(W))
                        : (word_q == nwords(fld) - 10'd1);

   assign head  = rp_q ? fifo1_q : fifo0_q;
   assign pop   = (cnt_q != 2'd0) && core_ready_i;
   assign push  = infl_q;
   assign pdata = infl_mlen_q ? W'(msg_len_q) : mem_data_i;
   assign cnt_d = cnt_q + 2'(push) - 2'(pop);

   // Credit check counts the word leaving this cycle so a full-rate
   // stream keeps one word buffered and one in flight.
   assign occ   = {1'b0, cnt_q} + 3'(infl_q) - 3'(pop);
   assign issue = (state_q == S_STREAM) && !iss_done_q && (occ < 3'd2);

   assign fin = iss_done_q && !infl_q && (cnt_q == 2'd1) && pop;

   assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

   // MLEN takes a slot in the read pipeline but never touches memory.
   assign mem_rd_o    = issue && !is_mlen;
   assign mem_field_o = mem_rd_o ? fld : 3'd0;
   assign mem_word_o  = mem_rd_o ? word_q : 10'd0;

   assign core_valid_o = (cnt_q != 2'd0);
   assign core_data_o  = core_valid_o ? head : '0;

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign accept_o     = accept_q;
   assign cyc_total_o  = tot_q;
   assign core_rst_o   = crst_q;
   assign core_start_o = cstart_q;
   assign core_ready_o = cready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rc_q        <= '0;
         msg_len_q   <= '0;
         msg_rem_q   <= '0;
         pos_q       <= '0;
         word_q      <= '0;
         iss_done_q  <= 1'b0;
         infl_q      <= 1'b0;
         infl_mlen_q <= 1'b0;
         fifo0_q     <= '0;
         fifo1_q     <= '0;
         rp_q        <= 1'b0;
         wp_q        <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         accept_q    <= 1'b0;
         cyc_q       <= '0;
         tot_q       <= '0;
         crst_q      <= 1'b0;
         cstart_q    <= 1'b0;
         cready_q    <= 1'b0;
      end else begin
         if (push) begin
            if (wp_q) fifo1_q <= pdata;
            else      fifo0_q <= pdata;
            wp_q <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         cnt_q       <= cnt_d;
         infl_q      <= issue;
         infl_mlen_q <= issue && is_mlen;

         if (issue) begin
            if (last) begin
               word_q <= '0;
               if (pos_q == 3'd6) iss_done_q <= 1'b1;
               else               pos_q      <= pos_q + 3'd1;
            end else begin
               word_q <= word_q + 10'd1;
               if (is_msg) msg_rem_q <= msg_rem_q - 35'(W);
            end
         end

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q   <= S_CRST;
                  msg_len_q <= msg_len_i;
                  busy_q    <= 1'b1;
                  crst_q    <= 1'b1;
                  rc_q      <= '0;
               end
            end
            S_CRST: begin
               if (rc_q == RC_LAST) begin
                  crst_q   <= 1'b0;
                  cstart_q <= 1'b1;
                  state_q  <= S_CSTART;
               end else begin
                  rc_q <= rc_q + 4'd1;
               end
            end
            S_CSTART: begin
               cstart_q   <= 1'b0;
               cyc_q      <= 32'd1;
               pos_q      <= '0;
               word_q     <= '0;
               msg_rem_q  <= {msg_len_q, 3'b000};
               iss_done_q <= 1'b0;
               state_q    <= S_STREAM;
            end
            S_STREAM: begin
               cyc_q <= cyc_inc;
               if (fin) begin
                  cready_q <= 1'b1;
                  state_q  <= S_RESULT;
               end
            end
            S_RESULT: begin
               cyc_q <= cyc_inc;
               if (core_valid_i) begin
                  accept_q <= (core_data_i != W'(HIGH_PERF));
                  tot_q    <= cyc_q;
                  cready_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dilithium_vy_sequencer.sv
// Bench for dilithium_vy_sequencer: two instances (HIGH_PERF=1 and 0) run
// side by side on shared stimulus against a queue-based stream model.
module tb_dilithium_vy_sequencer;

   localparam int W  = 64;
   localparam int SW = 4;
   localparam int ZW = 4;
   localparam int TW = 4;
   localparam int HW = 4;
   localparam int RC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic [31:0]   mlen = '0;
   logic          ready = 1'b1;
   logic          cvi = 1'b0;
   logic [W-1:0]  cdi = '0;
   bit            rdy_rand = 1'b0;

   logic          busy_a, done_a, acc_a, rd_a, crst_a, cstart_a, cv_a, cro_a;
   logic [31:0]   tot_a;
   logic [2:0]    fld_a;
   logic [9:0]    wd_a;
   logic [W-1:0]  md_a, cd_a;
   logic          busy_b, done_b, acc_b, rd_b, crst_b, cstart_b, cv_b, cro_b;
   logic [31:0]   tot_b;
   logic [2:0]    fld_b;
   logic [9:0]    wd_b;
   logic [W-1:0]  md_b, cd_b;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dilithium_vy_sequencer #(
      .W(W), .HIGH_PERF(1), .SEED_WORDS(SW), .Z_WORDS(ZW),
      .T1_WORDS(TW), .H_WORDS(HW), .RST_CYCLES(RC)
   ) dut_a (
      .clk(clk), .rst(rst), .start_i(start_i), .msg_len_i(mlen),
      .busy_o(busy_a), .done_o(done_a), .accept_o(acc_a),
      .cyc_total_o(tot_a), .mem_rd_o(rd_a), .mem_field_o(fld_a),
      .mem_word_o(wd_a), .mem_data_i(md_a), .core_rst_o(crst_a),
      .core_start_o(cstart_a), .core_valid_o(cv_a),
      .core_ready_i(ready), .core_data_o(cd_a), .core_valid_i(cvi),
      .core_ready_o(cro_a), .core_data_i(cdi)
   );

   dilithium_vy_sequencer #(
      .W(W), .HIGH_PERF(0), .SEED_WORDS(SW), .Z_WORDS(ZW),
      .T1_WORDS(TW), .H_WORDS(HW), .RST_CYCLES(RC)
   ) dut_b (
      .clk(clk), .rst(rst), .start_i(start_i), .msg_len_i(mlen),
      .busy_o(busy_b), .done_o(done_b), .accept_o(acc_b),
      .cyc_total_o(tot_b), .mem_rd_o(rd_b), .mem_field_o(fld_b),
      .mem_word_o(wd_b), .mem_data_i(md_b), .core_rst_o(crst_b),
      .core_start_o(cstart_b), .core_valid_o(cv_b),
      .core_ready_i(ready), .core_data_o(cd_b), .core_valid_i(cvi),
      .core_ready_o(cro_b), .core_data_i(cdi)
   );

   // Memory content encodes field and word so any misordering shows.
   function automatic logic [W-1:0] mval(input logic [2:0] f,
                                         input logic [9:0] w);
      return {24'hC0FFEE, 5'd0, f, 22'd0, w};
   endfunction

   always @(posedge clk) begin
      md_a <= rd_a ? mval(fld_a, wd_a) : 64'hBAD0_BAD0_BAD0_BAD0;
      md_b <= rd_b ? mval(fld_b, wd_b) : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   always @(posedge clk) begin
      #1;
      ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Stream monitor: collects handshaken words, stall stability,
   // core reset length and the start/result cycle indices.
   logic [W-1:0] got_a[$];
   logic [W-1:0] got_b[$];
   logic [W-1:0] hld_a, hld_b;
   bit           stl_a = 0, stl_b = 0;
   int           stall_bad = 0;
   int           nrst_a = 0, nrst_b = 0;
   int           cyc = 0, st_cyc = 0, hs_cyc = 0, f_hs = 0, l_hs = 0;

   always @(negedge clk) begin
      if (rst) begin
         stl_a = 0;
         stl_b = 0;
      end else begin
         if (start_i && !busy_a) begin
            got_a.delete();
            got_b.delete();
            nrst_a = 0;
            nrst_b = 0;
            stall_bad = 0;
         end
         if (stl_a && (!cv_a || cd_a !== hld_a)) stall_bad++;
         if (stl_b && (!cv_b || cd_b !== hld_b)) stall_bad++;
         stl_a = cv_a && !ready;
         stl_b = cv_b && !ready;
         hld_a = cd_a;
         hld_b = cd_b;
         if (cv_a && ready) begin
            if (got_a.size() == 0) f_hs = cyc;
            l_hs = cyc;
            got_a.push_back(cd_a);
         end
         if (cv_b && ready) got_b.push_back(cd_b);
         if (crst_a) nrst_a++;
         if (crst_b) nrst_b++;
         if (cstart_a) st_cyc = cyc;
         if (cvi && cro_a) hs_cyc = cyc;
      end
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [W-1:0] exp_a[$];
   logic [W-1:0] exp_b[$];

   // Expected stream built from field order and word-count rules.
   function automatic void build(input bit hp, input int unsigned len);
      int ord[7];
      int n;
      logic [W-1:0] v;
      if (hp) ord = '{0, 1, 2, 3, 4, 5, 6};
      else    ord = '{0, 3, 1, 2, 6, 4, 5};
      for (int i = 0; i < 7; i++) begin
         case (ord[i])
            0, 1:    n = SW;
            2:       n = ZW;
            3:       n = TW;
            6:       n = HW;
            4:       n = 1;
            default: n = (len == 0) ? 1 :
                         int'((64'(len) * 8 + W - 1) / W);
         endcase
         for (int w = 0; w < n; w++) begin
            if (ord[i] == 4) v = W'(len);
            else             v = mval(3'(ord[i]), 10'(w));
            if (hp) exp_a.push_back(v);
            else    exp_b.push_back(v);
         end
      end
   endfunction

   task automatic run_op(input int unsigned len, input bit rnd,
                         input bit poke, input logic [W-1:0] res);
      int k;
      int bad;
      bit ea;
      bit eb;
      ea = (res != 64'd1);
      eb = (res != 64'd0);
      exp_a.delete();
      exp_b.delete();
      build(1'b1, len);
      build(1'b0, len);
      rdy_rand = rnd;
      @(posedge clk); #1;
      start_i = 1'b1;
      mlen = len;
      @(posedge clk); #1;
      start_i = 1'b0;
      mlen = $urandom;
      for (k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (cro_a) break;
         if (poke && k == 12) start_i = 1'b1;
         if (poke && k == 13) start_i = 1'b0;
      end
      start_i = 1'b0;
      chk("result_reached_a", cro_a, 1);
      chk("result_reached_b", cro_b, 1);
      chk("busy_in_result", busy_a, 1);
      chk("core_rst_len_a", nrst_a, RC);
      chk("core_rst_len_b", nrst_b, RC);
      chk("word_count_a", got_a.size(), exp_a.size());
      chk("word_count_b", got_b.size(), exp_b.size());
      bad = -1;
      for (int i = 0; i < exp_a.size(); i++)
         if (bad < 0 && (i >= got_a.size() || got_a[i] !== exp_a[i]))
            bad = i;
      chk("stream_a_first_bad", bad, -1);
      bad = -1;
      for (int i = 0; i < exp_b.size(); i++)
         if (bad < 0 && (i >= got_b.size() || got_b[i] !== exp_b[i]))
            bad = i;
      chk("stream_b_first_bad", bad, -1);
      if (!rnd) chk("full_rate", l_hs - f_hs, exp_a.size() - 1);
      chk("stall_stable", stall_bad, 0);
      @(posedge clk); #1;
      cvi = 1'b1;
      cdi = res;
      @(posedge clk); #1;
      cvi = 1'b0;
      cdi = {$urandom, $urandom};
      @(negedge clk);
      chk("done_pulse_a", done_a, 1);
      chk("done_pulse_b", done_b, 1);
      chk("accept_a", acc_a, ea);
      chk("accept_b", acc_b, eb);
      chk("cyc_total_a", tot_a, hs_cyc - st_cyc);
      chk("cyc_total_b", tot_b, hs_cyc - st_cyc);
      @(negedge clk);
      chk("done_end_a", done_a, 0);
      chk("idle_busy_a", busy_a, 0);
      chk("idle_busy_b", busy_b, 0);
      chk("accept_hold_a", acc_a, ea);
      chk("cyc_total_hold_a", tot_a, hs_cyc - st_cyc);
   endtask

   initial begin
      int k;
      logic [W-1:0] r;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_accept", acc_a, 0);
      chk("rst_total", tot_a, 0);
      chk("rst_valid", cv_a, 0);
      chk("rst_memrd", rd_a, 0);
      chk("rst_crst", crst_a, 0);
      chk("rst_cstart", cstart_a, 0);
      chk("rst_cready", cro_a, 0);
      chk("rst_data", cd_a, 0);
      rst = 1'b0;

      run_op(33, 1'b0, 1'b0, 64'd0);
      run_op(33, 1'b0, 1'b0, 64'd1);
      run_op(33, 1'b1, 1'b1, 64'd0);
      run_op(0, 1'b1, 1'b0, 64'd1);
      run_op(8, 1'b1, 1'b0, 64'd0);
      run_op(9, 1'b1, 1'b0, 64'h55);

      rdy_rand = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b1;
      mlen = 33;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rd_a && fld_a == 3'd2) break;
      end
      chk("reached_z_field", fld_a, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy_a", busy_a, 0);
      chk("abort_valid_a", cv_a, 0);
      chk("abort_busy_b", busy_b, 0);
      chk("abort_valid_b", cv_b, 0);
      chk("abort_crst_a", crst_a, 0);
      chk("abort_done_a", done_a, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_idle_done", done_a, 0);
      chk("abort_idle_crst", crst_a, 0);
      run_op(33, 1'b1, 1'b0, 64'd0);

      r = {$urandom, $urandom};
      run_op($urandom_range(1, 200), 1'b1, 1'b0, r);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
